stage_e: RTL and testbench
==========================

STAGE_E -- requirements
Module: stage_e

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-low; reset is asserted while reset==0.
REQ-003 instr_E, ifunc_E, PC_E, BD_E, useRt_E, addrRt_E, addrRd_E  in  codebase types  instruction descriptor from stage D.
REQ-004 EXC_E  in  `TYPE_EXC  exception carried from earlier stages.
REQ-005 dataRs_E, dataRt_E  in  32  operands, already forwarded.
REQ-006 imm_E  in  32  extended immediate.
REQ-007 aluSrcImm  in  1  operand B select: 1 = imm_E, 0 = dataRt_E.
REQ-008 aluOp  in  4  ALU opcode, encoding in REQ-020.
REQ-009 mdOp  in  3  mult/div opcode: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO.
REQ-010 mfSel  in  2  HI/LO read: 0 none, 1 MFHI, 2 MFLO.
REQ-011 regWEn_E, regWAddr_E, regWData_E, regWValid_E, Tnew_E  in  codebase types  register-write descriptor.
REQ-012 stall, clear  in  1  pipeline control.
REQ-013 enMD  in  1  1 = no exception or interrupt is being taken this cycle; permits HI/LO side effects.
REQ-014 instr_M, ifunc_M, PC_M, BD_M, useRt_M, addrRt_M, addrRd_M, dataRt_M  out  codebase types  registered copies of the E inputs.
REQ-015 EXC_M  out  `TYPE_EXC  registered exception.
REQ-016 aluOut_M  out  32  registered ALU result.
REQ-017 regWEn_M, regWAddr_M, regWData_M, regWValid_M, Tnew_M  out  codebase types  registered register-write descriptor.
REQ-018 busyMD  out  1  combinational stall request to the hazard unit.

Function
REQ-019 A = dataRs_E; B = aluSrcImm ? imm_E : dataRt_E.
REQ-020 aluOp encoding:
- 0 ADD, overflow traps; 1 ADDU; 2 SUB, overflow traps; 3 SUBU.
- 4 AND; 5 OR; 6 XOR; 7 NOR.
- 8 SLT, signed; 9 SLTU.
- 10 SLL B by A[4:0]; 11 SRL B by A[4:0]; 12 SRA B by A[4:0].
- 13 LUI, result {B[15:0],16'b0}; 14 ADDA (address add); 15 pass B.
REQ-021 Signed overflow on ADD/SUB raises `EXC_OV; on ADDA raises `EXC_ADEL if ifunc_E==`I_MEM_R, otherwise `EXC_ADES.
REQ-022 EXC_M <= (EXC_E != 0) ? EXC_E : ALU exception.
REQ-023 Tnew_M <= (Tnew_E >= 1) ? Tnew_E-1 : 0.
REQ-024 regWData_M:
- regWValid_E ? regWData_E
- : mfSel==1 ? HI
- : mfSel==2 ? LO
- : ALU result.
REQ-025 regWValid_M <= regWValid_E | (Tnew_E <= 1).
REQ-026 Pipeline register update:
- stall: every output register holds.
- clear & ~stall: every output register loads 0.
- otherwise: every output register loads its next value.
REQ-027 MD unit state machine, states IDLE / BUSY; 4-bit counter cnt; internal registers HI, LO and shadow registers hiN, loN.
REQ-028 Start condition: IDLE & mdOp in 1..4 & ~stall & ~clear & enMD & EXC_E==0.
REQ-029 On start:
- compute the full product (MULT/MULTU) or quotient/remainder (DIV/DIVU) into hiN/loN; HI = high word or remainder, LO = low word or quotient.
- set cnt = 5 for multiply, 10 for divide.
- enter BUSY.
REQ-030 In BUSY, cnt decrements every cycle regardless of stall or clear.
REQ-031 In BUSY, at cnt==1: HI<=hiN, LO<=loN, return to IDLE on that edge.
REQ-032 Divide by zero: completes in 10 cycles; HI/LO are left unchanged.
REQ-033 MTHI/MTLO: write dataRs_E into HI/LO at the edge, only when in IDLE & ~stall & ~clear & enMD & EXC_E==0.
REQ-034 busyMD = BUSY & (mdOp!=0 | mfSel!=0); it is never asserted in IDLE.
REQ-035 An MD operation already started is never cancelled by clear, stall, or a later exception.
REQ-036 HI/LO values are visible to MFHI/MFLO in the cycle after commit.

Reset
REQ-037 While reset==0, all of the following are forced asynchronously:
- every output register = 0;
- HI = LO = hiN = loN = 0;
- cnt = 0, state IDLE, busyMD = 0.
REQ-038 Reset asserted mid-BUSY aborts the operation; HI/LO read 0 afterwards.

Verification
REQ-039 ADD with A=0x7FFFFFFF, B=1 -> EXC_M=`EXC_OV, aluOut_M=0x80000000; ADDU with the same operands -> EXC_M=0.
REQ-040 MULT A=0xFFFFFFFE, B=3 -> busyMD=0 on the start cycle; MFLO issued next cycle -> busyMD=1 for 4 cycles; then regWData_M=0xFFFFFFFA, and MFHI returns 0xFFFFFFFF.
REQ-041 DIVU 100/7 followed by back-to-back MFHI -> busyMD asserted until the 10th edge; then MFHI returns 2 and MFLO returns 14.
REQ-042 DIV with B=0 after MTLO 0x1234 -> after 10 cycles LO=0x1234 (unchanged).
REQ-043 MULT presented with enMD=0 or EXC_E!=0 -> no start, state stays IDLE; clear & ~stall -> all *_M outputs 0 next edge, while an MD operation already in flight still commits.
REQ-044 reset pulled low 3 cycles into a DIV -> outputs 0 immediately without waiting for a clock edge; after release MFHI returns 0 and busyMD=0.

Source files
------------

// File: rtl/stage_e.sv
// stage_e: execute stage of the pipeline, with the E/M pipeline register and
// the multiply/divide unit that owns the HI/LO registers.
//
// Ports:
//   clk, reset                    clock; asynchronous active-low reset
//   *_E (instr, ifunc, PC, BD, useRt, addrRt, addrRd, EXC)
//                                 instruction descriptor from stage D
//   dataRs_E, dataRt_E, imm_E     operands (already forwarded) and immediate
//   aluSrcImm, aluOp              operand B select and ALU opcode
//   mdOp, mfSel                   mult/div opcode and HI/LO read select
//   regW*_E, Tnew_E               register-write descriptor in
//   stall, clear                  pipeline control (hold / bubble)
//   enMD                          no exception/interrupt taken this cycle
//   *_M                           registered copies for stage M
//   aluOut_M                      registered ALU result
//   busyMD                        combinational stall request to hazard unit

`ifndef TYPE_EXC
`define TYPE_EXC logic [4:0]
`endif
`ifndef EXC_ADEL
`define EXC_ADEL 5'd4
`endif
`ifndef EXC_ADES
`define EXC_ADES 5'd5
`endif
`ifndef EXC_OV
`define EXC_OV 5'd12
`endif
`ifndef I_MEM_R
`define I_MEM_R 4'd2
`endif

module stage_e (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_E,
    input  logic [3:0]  ifunc_E,
    input  logic [31:0] PC_E,
    input  logic        BD_E,
    input  logic        useRt_E,
    input  logic [4:0]  addrRt_E,
    input  logic [4:0]  addrRd_E,
    input  `TYPE_EXC    EXC_E,
    input  logic [31:0] dataRs_E,
    input  logic [31:0] dataRt_E,
    input  logic [31:0] imm_E,
    input  logic        aluSrcImm,
    input  logic [3:0]  aluOp,
    input  logic [2:0]  mdOp,
    input  logic [1:0]  mfSel,
    input  logic        regWEn_E,
    input  logic [4:0]  regWAddr_E,
    input  logic [31:0] regWData_E,
    input  logic        regWValid_E,
    input  logic [1:0]  Tnew_E,
    input  logic        stall,
    input  logic        clear,
    input  logic        enMD,
    output logic [31:0] instr_M,
    output logic [3:0]  ifunc_M,
    output logic [31:0] PC_M,
    output logic        BD_M,
    output logic        useRt_M,
    output logic [4:0]  addrRt_M,
    output logic [4:0]  addrRd_M,
    output logic [31:0] dataRt_M,
    output `TYPE_EXC    EXC_M,
    output logic [31:0] aluOut_M,
    output logic        regWEn_M,
    output logic [4:0]  regWAddr_M,
    output logic [31:0] regWData_M,
    output logic        regWValid_M,
    output logic [1:0]  Tnew_M,
    output logic        busyMD
);

    typedef enum logic {IDLE, BUSY} md_state_t;

    md_state_t   state, state_n;
    logic [3:0]  cnt;
    logic [31:0] hi, lo, hi_n, lo_n;
    logic [31:0] hi_calc, lo_calc;

    logic [31:0] a, b;
    logic [32:0] sum, diff;
    logic [31:0] alu_res;
    logic        alu_ovf;
    `TYPE_EXC    alu_exc;

    logic [63:0] prod_s, prod_u;
    logic [31:0] div_bs, div_bu;
    logic [31:0] quot_s, rem_s, quot_u, rem_u;
    logic        md_gate, md_start, md_move;

    assign a = dataRs_E;
    assign b = aluSrcImm ? imm_E : dataRt_E;

    // One extra sign bit: overflow when the two top bits disagree.
    assign sum  = {a[31], a} + {b[31], b};
    assign diff = {a[31], a} - {b[31], b};

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (aluOp)
            4'd0:    begin alu_res = sum[31:0];  alu_ovf = sum[32] ^ sum[31];   end
            4'd1:    alu_res = sum[31:0];
            4'd2:    begin alu_res = diff[31:0]; alu_ovf = diff[32] ^ diff[31]; end
            4'd3:    alu_res = diff[31:0];
            4'd4:    alu_res = a & b;
            4'd5:    alu_res = a | b;
            4'd6:    alu_res = a ^ b;
            4'd7:    alu_res = ~(a | b);
            4'd8:    alu_res = {31'b0, $signed(a) < $signed(b)};
            4'd9:    alu_res = {31'b0, a < b};
            4'd10:   alu_res = b << a[4:0];
            4'd11:   alu_res = b >> a[4:0];
            4'd12:   alu_res = $signed(b) >>> a[4:0];
            4'd13:   alu_res = {b[15:0], 16'b0};
            4'd14:   begin alu_res = sum[31:0];  alu_ovf = sum[32] ^ sum[31];   end
            default: alu_res = b;
        endcase
    end

    always_comb begin
        alu_exc = '0;
        if (alu_ovf) begin
            if (aluOp == 4'd14)
                alu_exc = (ifunc_E == `I_MEM_R) ? `EXC_ADEL : `EXC_ADES;
            else
                alu_exc = `EXC_OV;
        end
    end

    // Divisors are steered to 1 for divide-by-zero (result discarded) and for
    // the signed 0x80000000 / -1 case, where dividing by 1 yields exactly the
    // wrapped quotient 0x80000000 and remainder 0.
    assign div_bu = (b == '0) ? 32'd1 : b;
    assign div_bs = ((b == '0) || (a == 32'h8000_0000 && b == '1)) ? 32'd1 : b;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'b0, a} * {32'b0, b};
    assign quot_s = $signed(a) / $signed(div_bs);
    assign rem_s  = $signed(a) % $signed(div_bs);
    assign quot_u = a / div_bu;
    assign rem_u  = a % div_bu;

    always_comb begin
        hi_calc = hi;
        lo_calc = lo;
        case (mdOp)
            3'd1: {hi_calc, lo_calc} = prod_s;
            3'd2: {hi_calc, lo_calc} = prod_u;
            3'd3: if (b != '0) begin hi_calc = rem_s; lo_calc = quot_s; end
            3'd4: if (b != '0) begin hi_calc = rem_u; lo_calc = quot_u; end
            default: ;
        endcase
    end

    assign md_gate  = (state == IDLE) && !stall && !clear && enMD && (EXC_E == '0);
    assign md_start = md_gate && (mdOp >= 3'd1) && (mdOp <= 3'd4);
    assign md_move  = md_gate && ((mdOp == 3'd5) || (mdOp == 3'd6));

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (md_start) state_n = BUSY;
            BUSY:    if (cnt == 4'd1) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busyMD = (state == BUSY) && ((mdOp != '0) || (mfSel != '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            hi_n  <= '0;
            lo_n  <= '0;
        end else begin
            state <= state_n;
            if (state == BUSY) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) begin
                    hi <= hi_n;
                    lo <= lo_n;
                end
            end else if (md_start) begin
                hi_n <= hi_calc;
                lo_n <= lo_calc;
                cnt  <= (mdOp <= 3'd2) ? 4'd5 : 4'd10;
            end else if (md_move) begin
                if (mdOp == 3'd5) hi <= a;
                else              lo <= a;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_M <= '0; ifunc_M <= '0; PC_M <= '0; BD_M <= '0;
            useRt_M <= '0; addrRt_M <= '0; addrRd_M <= '0; dataRt_M <= '0;
            EXC_M <= '0; aluOut_M <= '0; regWEn_M <= '0; regWAddr_M <= '0;
            regWData_M <= '0; regWValid_M <= '0; Tnew_M <= '0;
        end else if (stall) begin
            // hold every output register
        end else if (clear) begin
            instr_M <= '0; ifunc_M <= '0; PC_M <= '0; BD_M <= '0;
            useRt_M <= '0; addrRt_M <= '0; addrRd_M <= '0; dataRt_M <= '0;
            EXC_M <= '0; aluOut_M <= '0; regWEn_M <= '0; regWAddr_M <= '0;
            regWData_M <= '0; regWValid_M <= '0; Tnew_M <= '0;
        end else begin
            instr_M     <= instr_E;
            ifunc_M     <= ifunc_E;
            PC_M        <= PC_E;
            BD_M        <= BD_E;
            useRt_M     <= useRt_E;
            addrRt_M    <= addrRt_E;
            addrRd_M    <= addrRd_E;
            dataRt_M    <= dataRt_E;
            EXC_M       <= (EXC_E != '0) ? EXC_E : alu_exc;
            aluOut_M    <= alu_res;
            regWEn_M    <= regWEn_E;
            regWAddr_M  <= regWAddr_E;
            regWData_M  <= regWValid_E   ? regWData_E :
                           (mfSel == 2'd1) ? hi :
                           (mfSel == 2'd2) ? lo : alu_res;
            regWValid_M <= regWValid_E | (Tnew_E <= 2'd1);
            Tnew_M      <= (Tnew_E >= 2'd1) ? Tnew_E - 2'd1 : '0;
        end
    end

endmodule

// File: tb/tb_stage_e.sv
// tb_stage_e: directed vectors for stage_e. The driver pushes the expected
// stage-M response for every tagged instruction; a monitor pops and compares
// whenever a new tagged instruction appears on instr_M.

module tb_stage_e;

    localparam logic [4:0] X_ADEL = 5'd4;
    localparam logic [4:0] X_ADES = 5'd5;
    localparam logic [4:0] X_OV   = 5'd12;
    localparam logic [3:0] F_MEMR = 4'd2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_E, PC_E, dataRs_E, dataRt_E, imm_E, regWData_E;
    logic [3:0]  ifunc_E, aluOp;
    logic        BD_E, useRt_E, aluSrcImm, regWEn_E, regWValid_E;
    logic        stall, clear, enMD;
    logic [4:0]  addrRt_E, addrRd_E, EXC_E, regWAddr_E;
    logic [2:0]  mdOp;
    logic [1:0]  mfSel, Tnew_E;

    logic [31:0] instr_M, PC_M, dataRt_M, aluOut_M, regWData_M;
    logic [3:0]  ifunc_M;
    logic        BD_M, useRt_M, regWEn_M, regWValid_M, busyMD;
    logic [4:0]  addrRt_M, addrRd_M, EXC_M, regWAddr_M;
    logic [1:0]  Tnew_M;

    stage_e dut (
        .clk(clk), .reset(reset),
        .instr_E(instr_E), .ifunc_E(ifunc_E), .PC_E(PC_E), .BD_E(BD_E),
        .useRt_E(useRt_E), .addrRt_E(addrRt_E), .addrRd_E(addrRd_E),
        .EXC_E(EXC_E), .dataRs_E(dataRs_E), .dataRt_E(dataRt_E), .imm_E(imm_E),
        .aluSrcImm(aluSrcImm), .aluOp(aluOp), .mdOp(mdOp), .mfSel(mfSel),
        .regWEn_E(regWEn_E), .regWAddr_E(regWAddr_E), .regWData_E(regWData_E),
        .regWValid_E(regWValid_E), .Tnew_E(Tnew_E),
        .stall(stall), .clear(clear), .enMD(enMD),
        .instr_M(instr_M), .ifunc_M(ifunc_M), .PC_M(PC_M), .BD_M(BD_M),
        .useRt_M(useRt_M), .addrRt_M(addrRt_M), .addrRd_M(addrRd_M),
        .dataRt_M(dataRt_M), .EXC_M(EXC_M), .aluOut_M(aluOut_M),
        .regWEn_M(regWEn_M), .regWAddr_M(regWAddr_M), .regWData_M(regWData_M),
        .regWValid_M(regWValid_M), .Tnew_M(Tnew_M), .busyMD(busyMD)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] tag;
        logic [4:0]  exc;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [1:0]  tnew;
        logic        wvalid;
    } exp_t;

    exp_t        sb[$];
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] tag_ctr = '0;
    logic [31:0] last_tag = '0;
    logic [1:0]  exp_tnew;
    logic        exp_wvalid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    function automatic logic [31:0] pc_of(input logic [31:0] t);
        return 32'h0040_0000 + (t << 2);
    endfunction

    // Monitor: compares each newly captured tagged instruction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset && instr_M != '0 && instr_M != last_tag) begin
                last_tag = instr_M;
                if (sb.size() == 0) begin
                    check("unexpected_output", instr_M, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("tag",    instr_M, e.tag);
                    check("exc",    32'(EXC_M), 32'(e.exc));
                    check("alu",    aluOut_M, e.alu);
                    check("wdata",  regWData_M, e.wdata);
                    check("tnew",   32'(Tnew_M), 32'(e.tnew));
                    check("wvalid", 32'(regWValid_M), 32'(e.wvalid));
                    check("pc",     PC_M, pc_of(e.tag));
                end
            end
        end
    end

    task automatic set_default();
        instr_E = '0; ifunc_E = '0; PC_E = '0; BD_E = 1'b0; useRt_E = 1'b0;
        addrRt_E = '0; addrRd_E = '0; EXC_E = '0; dataRs_E = '0; dataRt_E = '0;
        imm_E = '0; aluSrcImm = 1'b0; aluOp = '0; mdOp = '0; mfSel = '0;
        regWEn_E = 1'b0; regWAddr_E = '0; regWData_E = '0; regWValid_E = 1'b0;
        Tnew_E = 2'd2; stall = 1'b0; clear = 1'b0; enMD = 1'b1;
        exp_tnew = 2'd1; exp_wvalid = 1'b0;
    endtask

    // Called at a negedge with inputs set. While busyMD is raised the bench
    // acts as the hazard unit and bubbles stage M. Returns at the next negedge.
    task automatic go(input bit chk, input logic [4:0] e_exc, input logic [31:0] e_alu,
                      input logic [31:0] e_wdata, output int busy_cycles);
        exp_t e;
        busy_cycles = 0;
        if (chk) begin
            tag_ctr = tag_ctr + 1;
            instr_E = tag_ctr;
            PC_E    = pc_of(tag_ctr);
        end
        #1;
        while (busyMD && busy_cycles < 40) begin
            clear = 1'b1;
            @(posedge clk);
            busy_cycles++;
            @(negedge clk);
            clear = 1'b0;
            #1;
        end
        if (busyMD) check("busy_timeout", 32'(busyMD), 32'd0);
        if (chk) begin
            e.tag = tag_ctr; e.exc = e_exc; e.alu = e_alu; e.wdata = e_wdata;
            e.tnew = exp_tnew; e.wvalid = exp_wvalid;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        set_default();
    endtask

    initial begin
        int bc;
        reset = 1'b0;
        set_default();
        repeat (2) @(negedge clk);
        check("rst_alu",   aluOut_M, 32'd0);
        check("rst_exc",   32'(EXC_M), 32'd0);
        check("rst_wdata", regWData_M, 32'd0);
        check("rst_tnew",  32'(Tnew_M), 32'd0);
        check("rst_instr", instr_M, 32'd0);
        check("rst_busy",  32'(busyMD), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // ALU vectors
        aluOp = 4'd0; dataRs_E = 32'h7FFF_FFFF; dataRt_E = 32'd1;
        go(1, X_OV, 32'h8000_0000, 32'h8000_0000, bc);
        aluOp = 4'd1; dataRs_E = 32'h7FFF_FFFF; dataRt_E = 32'd1;
        go(1, 5'd0, 32'h8000_0000, 32'h8000_0000, bc);
        aluOp = 4'd2; dataRs_E = 32'h8000_0000; dataRt_E = 32'd1;
        go(1, X_OV, 32'h7FFF_FFFF, 32'h7FFF_FFFF, bc);
        aluOp = 4'd8; dataRs_E = 32'hFFFF_FFFF; dataRt_E = 32'd1;
        go(1, 5'd0, 32'd1, 32'd1, bc);
        aluOp = 4'd9; dataRs_E = 32'hFFFF_FFFF; dataRt_E = 32'd1;
        go(1, 5'd0, 32'd0, 32'd0, bc);
        aluOp = 4'd12; dataRs_E = 32'd4; dataRt_E = 32'h8000_0000;
        go(1, 5'd0, 32'hF800_0000, 32'hF800_0000, bc);
        aluOp = 4'd10; dataRs_E = 32'd36; dataRt_E = 32'd1;
        go(1, 5'd0, 32'h10, 32'h10, bc);
        aluOp = 4'd13; aluSrcImm = 1'b1; imm_E = 32'h1234; dataRt_E = 32'hFFFF;
        go(1, 5'd0, 32'h1234_0000, 32'h1234_0000, bc);
        aluOp = 4'd7; dataRt_E = 32'hFF;
        go(1, 5'd0, 32'hFFFF_FF00, 32'hFFFF_FF00, bc);
        aluOp = 4'd14; ifunc_E = F_MEMR; dataRs_E = 32'h7FFF_FFFF; dataRt_E = 32'd1;
        go(1, X_ADEL, 32'h8000_0000, 32'h8000_0000, bc);
        aluOp = 4'd14; ifunc_E = 4'd3; dataRs_E = 32'h7FFF_FFFF; dataRt_E = 32'd1;
        go(1, X_ADES, 32'h8000_0000, 32'h8000_0000, bc);
        aluOp = 4'd0; EXC_E = 5'd7; dataRs_E = 32'h7FFF_FFFF; dataRt_E = 32'd1;
        go(1, 5'd7, 32'h8000_0000, 32'h8000_0000, bc);

        // Register-write descriptor
        aluOp = 4'd1; dataRs_E = 32'd1; dataRt_E = 32'd1; Tnew_E = 2'd1;
        exp_tnew = 2'd0; exp_wvalid = 1'b1;
        go(1, 5'd0, 32'd2, 32'd2, bc);
        aluOp = 4'd1; dataRs_E = 32'd1; dataRt_E = 32'd1; Tnew_E = 2'd0;
        exp_tnew = 2'd0; exp_wvalid = 1'b1;
        go(1, 5'd0, 32'd2, 32'd2, bc);
        aluOp = 4'd1; dataRs_E = 32'd1; dataRt_E = 32'd1; Tnew_E = 2'd3;
        regWValid_E = 1'b1; regWData_E = 32'hABCD;
        exp_tnew = 2'd2; exp_wvalid = 1'b1;
        go(1, 5'd0, 32'd2, 32'hABCD, bc);

        // MULT -2 * 3, idle cycle, then MFLO stalls for 4 cycles
        aluOp = 4'd15; mdOp = 3'd1; dataRs_E = 32'hFFFF_FFFE; dataRt_E = 32'd3;
        go(1, 5'd0, 32'd3, 32'd3, bc);
        check("mult_start_busy", 32'(bc), 32'd0);
        go(0, 5'd0, 32'd0, 32'd0, bc);
        mfSel = 2'd2;
        go(1, 5'd0, 32'd0, 32'hFFFF_FFFA, bc);
        check("mflo_busy_cycles", 32'(bc), 32'd4);
        mfSel = 2'd1;
        go(1, 5'd0, 32'd0, 32'hFFFF_FFFF, bc);

        // DIVU 100/7 then immediate MFHI
        mdOp = 3'd4; dataRs_E = 32'd100; dataRt_E = 32'd7;
        go(0, 5'd0, 32'd0, 32'd0, bc);
        mfSel = 2'd1;
        go(1, 5'd0, 32'd0, 32'd2, bc);
        check("divu_busy_cycles", 32'(bc), 32'd10);
        mfSel = 2'd2;
        go(1, 5'd0, 32'd0, 32'd14, bc);

        // MTLO then DIV by zero leaves HI/LO untouched
        mdOp = 3'd6; dataRs_E = 32'h1234;
        go(0, 5'd0, 32'd0, 32'd0, bc);
        mdOp = 3'd3; dataRs_E = 32'd5; dataRt_E = 32'd0;
        go(0, 5'd0, 32'd0, 32'd0, bc);
        mfSel = 2'd2;
        go(1, 5'd0, 32'd0, 32'h1234, bc);
        check("div0_busy_cycles", 32'(bc), 32'd10);
        mfSel = 2'd1;
        go(1, 5'd0, 32'd0, 32'd2, bc);

        // MULT suppressed by enMD=0 and by a pending exception
        mdOp = 3'd1; dataRs_E = 32'd2; dataRt_E = 32'd3; enMD = 1'b0;
        go(0, 5'd0, 32'd0, 32'd0, bc);
        mfSel = 2'd2;
        go(1, 5'd0, 32'd0, 32'h1234, bc);
        check("nomd_busy", 32'(bc), 32'd0);
        mdOp = 3'd1; dataRs_E = 32'd2; dataRt_E = 32'd3; EXC_E = 5'd5;
        go(1, 5'd5, 32'd5, 32'd5, bc);
        mfSel = 2'd1;
        go(1, 5'd0, 32'd0, 32'd2, bc);
        check("exc_busy", 32'(bc), 32'd0);

        // clear flushes stage M but an in-flight MULT still commits
        mdOp = 3'd1; dataRs_E = 32'h1_0000; dataRt_E = 32'h1_0000;
        go(0, 5'd0, 32'd0, 32'd0, bc);
        check("pre_clear_alu", aluOut_M, 32'h2_0000);
        repeat (2) begin
            instr_E = 32'hFFFF; PC_E = 32'h1000; aluOp = 4'd15; dataRt_E = 32'h55;
            clear = 1'b1;
            @(posedge clk);
            #1;
            check("clr_instr", instr_M, 32'd0);
            check("clr_alu",   aluOut_M, 32'd0);
            check("clr_pc",    PC_M, 32'd0);
            check("clr_tnew",  32'(Tnew_M), 32'd0);
            @(negedge clk);
            set_default();
        end
        mfSel = 2'd1;
        go(1, 5'd0, 32'd0, 32'd1, bc);
        check("clr_mfhi_busy", 32'(bc), 32'd3);
        mfSel = 2'd2;
        go(1, 5'd0, 32'd0, 32'd0, bc);

        // stall holds stage M
        aluOp = 4'd1; dataRs_E = 32'd1; dataRt_E = 32'd2;
        go(1, 5'd0, 32'd3, 32'd3, bc);
        aluOp = 4'd1; dataRs_E = 32'd5; instr_E = 32'h7777; PC_E = 32'h1000; stall = 1'b1;
        @(posedge clk);
        #1;
        check("stall_alu",   aluOut_M, 32'd3);
        check("stall_instr", instr_M, tag_ctr);
        check("stall_pc",    PC_M, pc_of(tag_ctr));
        @(negedge clk);
        set_default();

        // reset 3 cycles into a DIVU
        mdOp = 3'd4; dataRs_E = 32'd100; dataRt_E = 32'd7;
        go(0, 5'd0, 32'd0, 32'd0, bc);
        repeat (3) begin
            aluOp = 4'd15; dataRt_E = 32'hDEAD;
            @(posedge clk);
            @(negedge clk);
        end
        check("pre_rst_alu", aluOut_M, 32'hDEAD);
        mfSel = 2'd1;
        #2;
        reset = 1'b0;
        #1;
        check("arst_alu",  aluOut_M, 32'd0);
        check("arst_tnew", 32'(Tnew_M), 32'd0);
        check("arst_busy", 32'(busyMD), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        set_default();
        mfSel = 2'd1;
        go(1, 5'd0, 32'd0, 32'd0, bc);
        check("post_rst_busy", 32'(bc), 32'd0);
        mfSel = 2'd2;
        go(1, 5'd0, 32'd0, 32'd0, bc);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
